// File: rtl/tx_packet_ctrl.sv
// Transmit packet sequencer: SYNC, PID, payload from TX FIFO, CRC16, EOP.
// Drives byte loads, timer control, CRC gating and done/underrun status.
module tx_packet_ctrl #(
  parameter int unsigned MAX_LEN = 64,
  parameter int unsigned LEN_W   = 7
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             tx_start,
  input  logic [3:0]       tx_pid,
  input  logic [LEN_W-1:0] tx_len,
  input  logic             fifo_empty,
  input  logic [7:0]       fifo_rdata,
  output logic             fifo_rd,
  input  logic [15:0]      crc_in,
  output logic             crc_clr,
  output logic             crc_en,
  input  logic             bit_strobe,
  input  logic             byte_done,
  output logic             load_en,
  output logic [7:0]       load_data,
  output logic             timer_en,
  output logic             timer_clr,
  output logic             tx_eop,
  output logic             tx_busy,
  output logic             tx_done,
  output logic             tx_error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_PID,
    S_DATA,
    S_CRC_LO,
    S_CRC_HI,
    S_EOP,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [3:0]       r_pid;
  logic [LEN_W-1:0] r_rem;
  logic [7:0]       r_crc_hi;
  logic [1:0]       r_eop_cnt;

  logic       r_fifo_rd;
  logic       r_crc_clr;
  logic       r_crc_en;
  logic       r_load_en;
  logic [7:0] r_load_data;
  logic       r_timer_en;
  logic       r_timer_clr;
  logic       r_tx_eop;
  logic       r_tx_busy;
  logic       r_tx_done;
  logic       r_tx_error;

  logic w_len_bad;
  logic w_last;

  assign w_len_bad = (tx_len > LEN_W'(MAX_LEN));
  assign w_last    = (r_rem == '0);

  // Entry actions for each byte state are issued on the transition edge so
  // that every output stays registered and lands one cycle after the cause.
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      r_state     <= S_IDLE;
      r_pid       <= '0;
      r_rem       <= '0;
      r_crc_hi    <= '0;
      r_eop_cnt   <= '0;
      r_fifo_rd   <= 1'b0;
      r_crc_clr   <= 1'b0;
      r_crc_en    <= 1'b0;
      r_load_en   <= 1'b0;
      r_load_data <= '0;
      r_timer_en  <= 1'b0;
      r_timer_clr <= 1'b0;
      r_tx_eop    <= 1'b0;
      r_tx_busy   <= 1'b0;
      r_tx_done   <= 1'b0;
      r_tx_error  <= 1'b0;
    end else begin
      r_fifo_rd   <= 1'b0;
      r_crc_clr   <= 1'b0;
      r_crc_en    <= 1'b0;
      r_load_en   <= 1'b0;
      r_timer_clr <= 1'b0;
      r_tx_done   <= 1'b0;
      r_tx_error  <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (tx_start) begin
            if (w_len_bad) begin
              r_tx_error <= 1'b1;
            end else begin
              r_pid       <= tx_pid;
              r_rem       <= tx_len;
              r_state     <= S_SYNC;
              r_tx_busy   <= 1'b1;
              r_load_en   <= 1'b1;
              r_load_data <= 8'h80;
              r_crc_clr   <= 1'b1;
              r_timer_clr <= 1'b1;
              r_timer_en  <= 1'b1;
            end
          end
        end

        S_SYNC: begin
          if (byte_done) begin
            r_state     <= S_PID;
            r_load_en   <= 1'b1;
            r_load_data <= {~r_pid, r_pid};
          end
        end

        // PID and DATA share the exit decision: CRC when no payload remains,
        // otherwise another DATA entry (which may detect an underrun).
        S_PID, S_DATA: begin
          if (byte_done) begin
            if (w_last) begin
              r_state     <= S_CRC_LO;
              r_load_en   <= 1'b1;
              r_load_data <= crc_in[7:0];
              r_crc_hi    <= crc_in[15:8];
            end else if (fifo_empty) begin
              r_state    <= S_EOP;
              r_tx_error <= 1'b1;
              r_tx_eop   <= 1'b1;
              r_eop_cnt  <= '0;
            end else begin
              r_state     <= S_DATA;
              r_load_en   <= 1'b1;
              r_fifo_rd   <= 1'b1;
              r_crc_en    <= 1'b1;
              r_load_data <= fifo_rdata;
              r_rem       <= r_rem - 1'b1;
            end
          end
        end

        S_CRC_LO: begin
          if (byte_done) begin
            r_state     <= S_CRC_HI;
            r_load_en   <= 1'b1;
            r_load_data <= r_crc_hi;
          end
        end

        S_CRC_HI: begin
          if (byte_done) begin
            r_state   <= S_EOP;
            r_tx_eop  <= 1'b1;
            r_eop_cnt <= '0;
          end
        end

        // Two SE0 bits plus one J bit.
        S_EOP: begin
          if (bit_strobe) begin
            if (r_eop_cnt == 2'd2) begin
              r_state    <= S_DONE;
              r_tx_eop   <= 1'b0;
              r_tx_done  <= 1'b1;
              r_timer_en <= 1'b0;
            end else begin
              r_eop_cnt <= r_eop_cnt + 2'd1;
            end
          end
        end

        S_DONE: begin
          r_state   <= S_IDLE;
          r_tx_busy <= 1'b0;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign fifo_rd   = r_fifo_rd;
  assign crc_clr   = r_crc_clr;
  assign crc_en    = r_crc_en;
  assign load_en   = r_load_en;
  assign load_data = r_load_data;
  assign timer_en  = r_timer_en;
  assign timer_clr = r_timer_clr;
  assign tx_eop    = r_tx_eop;
  assign tx_busy   = r_tx_busy;
  assign tx_done   = r_tx_done;
  assign tx_error  = r_tx_error;

endmodule

// File: doc/tx_packet_ctrl.md
# tx_packet_ctrl

Transmit-side packet sequencer for the USB bulk-transfer path. On a start request it drives one complete packet: SYNC byte, PID byte, 0..MAX_LEN payload bytes pulled from the TX FIFO, two CRC16 bytes, then EOP. It generates byte loads for the TX shift register, runs and clears the bit/byte timer, gates the CRC16 generator, and reports done or underrun to the protocol layer.

## Interface
- MAX_LEN, 64: maximum payload bytes per packet (bulk max packet size).
- LEN_W, 7: width of the length field; must hold MAX_LEN.

- clk  in  1  system clock
- n_rst  in  1  asynchronous reset, active-high (1 = reset); the name is kept per codebase convention
- tx_start  in  1  packet request; sampled only in IDLE
- tx_pid  in  4  PID nibble; latched on an accepted tx_start
- tx_len  in  LEN_W  payload byte count; latched on an accepted tx_start
- fifo_empty  in  1  TX FIFO empty
- fifo_rdata  in  8  TX FIFO head byte
- fifo_rd  out  1  FIFO pop, one-cycle pulse
- crc_in  in  16  current CRC16 value from the CRC block
- crc_clr  out  1  CRC block clear, one-cycle pulse
- crc_en  out  1  CRC block update with load_data, one-cycle pulse
- bit_strobe  in  1  one-cycle pulse per bit period, from the timer
- byte_done  in  1  one-cycle pulse after 8 bits, from the timer
- load_en  out  1  shift-register parallel load, one-cycle pulse
- load_data  out  8  byte to load; LSB is transmitted first
- timer_en  out  1  timer count enable
- timer_clr  out  1  timer clear, one-cycle pulse
- tx_eop  out  1  drive SE0/EOP on the line
- tx_busy  out  1  packet in progress
- tx_done  out  1  packet complete, one-cycle pulse
- tx_error  out  1  rejected request or FIFO underrun, one-cycle pulse

## Operation
- States: IDLE, SYNC, PID, DATA, CRC_LO, CRC_HI, EOP, DONE.
- Reset:
  - State = IDLE; all outputs = 0; load_data = 8'h00.
  - Applies asynchronously, including mid-packet; no tx_done or tx_error is issued for an aborted packet.
- IDLE, tx_start = 1:
  - If tx_len > MAX_LEN: pulse tx_error and stay in IDLE.
  - Otherwise: latch tx_pid and tx_len into the remaining-byte counter, then go to SYNC.
- Byte load rule: on each byte-state entry, pulse load_en for one cycle. Each byte state exits on byte_done.
- SYNC:
  - load_data = 8'h80.
  - crc_clr and timer_clr pulse in the same cycle as load_en.
  - timer_en = 1 from this cycle until DONE.
- PID:
  - load_data = {~pid, pid}.
  - On byte_done: go to CRC_LO if remaining = 0, else to DATA.
- DATA, at each byte entry:
  - If fifo_empty = 1: underrun. No load_en. Pulse tx_error and go directly to EOP.
  - Else: pulse load_en, fifo_rd and crc_en together; load_data = fifo_rdata; remaining decrements by 1.
- DATA, on byte_done:
  - remaining = 0: go to CRC_LO.
  - Otherwise: re-enter DATA for the next byte.
- CRC_LO: load_data = crc_in[7:0].
- CRC_HI: load_data = crc_in[15:8].
- crc_in is sampled at CRC_LO entry and held for CRC_HI.
- EOP:
  - tx_eop = 1; no loads.
  - Count 3 bit_strobe pulses (2 SE0 bits and 1 J bit), then go to DONE.
- DONE:
  - Pulse tx_done; timer_en = 0; return to IDLE.
- tx_busy = 1 in every state except IDLE.
- Ignored inputs:
  - tx_start outside IDLE.
  - byte_done and bit_strobe in IDLE and DONE.
  - byte_done during EOP.

## Timing
- Accepted tx_start at cycle 0: SYNC load_en, crc_clr and timer_clr at cycle 1.
- byte_done at cycle k: next byte's load_en (or underrun tx_error) at cycle k+1.
- Third bit_strobe in EOP at cycle m: tx_eop falls and tx_done pulses at cycle m+1; tx_busy = 0 from cycle m+2.
- All outputs are registered; no combinational input-to-output path.
- tx_len = 0: PID is followed directly by CRC_LO; no fifo_rd is issued.
- tx_len = MAX_LEN: accepted; counter wraps never occur because remaining stops at 0.
- byte_done and bit_strobe in the same cycle: byte_done takes priority for state transitions.

## Test plan
- Reset released, no stimulus -> all outputs 0, tx_busy = 0 indefinitely.
- tx_start, pid = 4'h3, len = 2, FIFO holds AA, 55, crc_in = 16'hBEEF -> load_data sequence 80, C3, AA, 55, EF, BE; exactly 2 fifo_rd and 2 crc_en; 3 bit_strobe of tx_eop; 1 tx_done.
- len = 0, pid = 4'hB -> loads 80, 4B, CRC_LO, CRC_HI; no fifo_rd; tx_done.
- len = 3 with FIFO empty before byte 2 -> 1 fifo_rd; tx_error at the cycle after byte_done; EOP follows; tx_done still pulses.
- tx_len = MAX_LEN+1 -> tx_error pulse at cycle 1; tx_busy stays 0; no load_en.
- Reset asserted in DATA, then tx_start again -> immediate return to IDLE with outputs 0; no tx_done; new packet starts cleanly at SYNC.
